// File: rtl/madd_err_acc.sv
// Error-statistics accumulator for the 6x6 multiply-add approximate circuits.
// Compares each approximate result against the exact a*b+c and tracks run-wide error figures.
module madd_err_acc #(
   parameter int N_SAMPLES = 262144,
   parameter int CNT_W     = 32,
   parameter int SUM_W     = 44
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [17:0]      in_operands,
   input  logic [11:0]      in_approx,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] sample_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [SUM_W-1:0] sum_abs_err,
   output logic [11:0]      max_abs_err,
   output logic [17:0]      max_err_operands
);

   if (N_SAMPLES < 1 || SUM_W < 12 || (CNT_W < 31 && N_SAMPLES >= (1 << CNT_W))) begin : g_bad_params
      $error("madd_err_acc: N_SAMPLES must be >= 1 and fit in CNT_W bits; SUM_W must be >= 12");
   end

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

   state_t            state;
   logic [CNT_W-1:0]  accepted;
   logic              accept;
   logic              launch;

   logic              s1_valid;
   logic [17:0]       s1_ops;
   logic [11:0]       s1_approx;
   logic [11:0]       s1_exact;
   logic signed [12:0] s1_diff;
   logic [11:0]       s1_abs;

   logic              s2_valid;
   logic [17:0]       s2_ops;
   logic [11:0]       s2_abs;
   logic              s2_err;

   logic [SUM_W:0]    sum_wide;

   assign accept = in_valid & in_ready;
   assign launch = start & ((state == IDLE) | (state == DONE));

   // Exact result never exceeds 4032, so 12 bits are enough; the 13-bit signed
   // difference against the approximation keeps the magnitude exact.
   always_comb begin
      s1_exact = 12'(s1_ops[5:0]) * 12'(s1_ops[11:6]) + 12'(s1_ops[17:12]);
      s1_diff  = $signed({1'b0, s1_exact}) - $signed({1'b0, s1_approx});
      s1_abs   = s1_diff[12] ? 12'(-s1_diff) : s1_diff[11:0];
   end

   assign sum_wide = {1'b0, sum_abs_err} + {{(SUM_W - 11){1'b0}}, s2_abs};

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_ops    <= '0;
         s1_approx <= '0;
         s2_valid  <= 1'b0;
         s2_ops    <= '0;
         s2_abs    <= '0;
         s2_err    <= 1'b0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_ops    <= in_operands;
            s1_approx <= in_approx;
         end
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_ops <= s1_ops;
            s2_abs <= s1_abs;
            s2_err <= (s1_abs != 12'd0);
         end
      end
   end

   // Run control: in_ready, busy and done are all registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         in_ready <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         accepted <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state    <= RUN;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  accepted <= '0;
               end
            end
            RUN: begin
               if (accept) begin
                  accepted <= accepted + 1'b1;
                  if (accepted == LAST_IDX) begin
                     state    <= DRAIN;
                     in_ready <= 1'b0;
                  end
               end
            end
            DRAIN: begin
               if (!s1_valid && !s2_valid) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Ties on the maximum keep the earlier vector, hence the strict compare.
   always_ff @(posedge clk) begin
      if (rst || launch) begin
         sample_cnt       <= '0;
         err_cnt          <= '0;
         sum_abs_err      <= '0;
         max_abs_err      <= '0;
         max_err_operands <= '0;
      end else if (s2_valid) begin
         sample_cnt  <= sample_cnt + 1'b1;
         err_cnt     <= err_cnt + CNT_W'(s2_err);
         sum_abs_err <= sum_wide[SUM_W] ? {SUM_W{1'b1}} : sum_wide[SUM_W-1:0];
         if (s2_abs > max_abs_err) begin
            max_abs_err      <= s2_abs;
            max_err_operands <= s2_ops;
         end
      end
   end

endmodule
